eviction_write_buffer: RTL and testbench

//  Dirty-line write buffer between the D-cache memory side and the I/D memory arbiter.

---
 rtl/ewb_pkg.sv | 15 +
 rtl/ewb_entry_array.sv | 87 ++++++++
 rtl/eviction_write_buffer.sv | 148 ++++++++++++++
 tb/tb_eviction_write_buffer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ewb_pkg.sv
// Shared types and helpers for the dcache eviction write buffer.
package ewb_pkg;
  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned S_OFFSET_DEF = 5;
  localparam int unsigned LINE_W       = 8 * (2 ** S_OFFSET_DEF);

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {U_IDLE, U_RESP, U_WAIT} u_state_t;
  typedef enum logic [1:0] {D_IDLE, D_READ, D_WRITE} d_state_t;

  function automatic int unsigned tag_width(input int unsigned s_offset);
    return ADDR_W - s_offset;
  endfunction
endpackage

// File: rtl/ewb_entry_array.sv
// Circular FIFO of buffered dirty lines with parallel tag lookup.
module ewb_entry_array
  import ewb_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned TAG_W  = 27,
  parameter int unsigned LINE_BITS = 256,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [TAG_W-1:0]     tag,
  input  logic [LINE_BITS-1:0] wr_data,
  input  logic                 in_flight,
  input  logic                 enq,
  input  logic                 merge,
  input  logic                 pop,
  output logic                 hit,
  output logic                 hit_in_flight,
  output logic [LINE_BITS-1:0] hit_data,
  output logic [TAG_W-1:0]     head_tag,
  output logic [LINE_BITS-1:0] head_data,
  output logic                 full,
  output logic                 empty
);
  logic [DEPTH-1:0]     valid;
  logic [TAG_W-1:0]     tag_q  [DEPTH];
  logic [LINE_BITS-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]     head, tail, hit_idx, idx_new;
  logic [CNT_W-1:0]     count, count_nxt;
  logic                 hit_new, hit_head_fl;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A newer copy of the draining line wins over the in-flight head.
  always_comb begin
    hit_new = 1'b0;
    idx_new = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && tag_q[i] == tag && !(in_flight && PTR_W'(i) == head)) begin
        hit_new = 1'b1;
        idx_new = PTR_W'(i);
      end
    end
    hit_head_fl   = in_flight && valid[head] && tag_q[head] == tag;
    hit           = hit_new || hit_head_fl;
    hit_in_flight = !hit_new && hit_head_fl;
    hit_idx       = hit_new ? idx_new : head;
  end

  assign hit_data  = data_q[hit_idx];
  assign head_tag  = tag_q[head];
  assign head_data = data_q[head];
  assign full      = (count == CNT_W'(DEPTH));
  assign count_nxt = count + CNT_W'(enq) - CNT_W'(pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      empty <= 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= ptr_inc(head);
      end
      if (enq) begin
        valid[tail]  <= 1'b1;
        tag_q[tail]  <= tag;
        data_q[tail] <= wr_data;
        tail         <= ptr_inc(tail);
      end
      if (merge) data_q[hit_idx] <= wr_data;
      count <= count_nxt;
      empty <= (count_nxt == '0);
    end
  end
endmodule

// File: rtl/eviction_write_buffer.sv
// Dirty-line write buffer between dcache and memory arbiter; fills bypass queued writebacks.
module eviction_write_buffer
  import ewb_pkg::*;
#(
  parameter int unsigned S_OFFSET = S_OFFSET_DEF,
  parameter int unsigned DEPTH    = 2,
  localparam int unsigned LINE_BITS = 8 * (2 ** S_OFFSET),
  localparam int unsigned TAG_W     = tag_width(S_OFFSET)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [LINE_BITS-1:0] line_i,
  input  logic [31:0]          address_i,
  input  logic                 read_i,
  input  logic                 write_i,
  output logic [LINE_BITS-1:0] line_o,
  output logic                 resp_o,
  output logic [LINE_BITS-1:0] dn_line_o,
  output logic [31:0]          dn_addr_o,
  output logic                 dn_read_o,
  output logic                 dn_write_o,
  input  logic [LINE_BITS-1:0] dn_line_i,
  input  logic                 dn_resp_i,
  output logic                 empty_o
);
  u_state_t u_state, u_nxt;
  d_state_t d_state, d_nxt;

  logic [TAG_W-1:0]     req_tag, fill_tag, head_tag;
  logic [LINE_BITS-1:0] hit_data, head_data;
  logic hit, hit_in_flight, full, empty;
  logic enq, merge, pop, load_hit, load_fill, post_fill;
  logic unused_offset;

  assign req_tag       = address_i[31:S_OFFSET];
  assign unused_offset = ^address_i[S_OFFSET-1:0];

  ewb_entry_array #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .LINE_BITS(LINE_BITS)
  ) u_entries (
    .clk(clk), .reset_n(reset_n), .tag(req_tag), .wr_data(line_i),
    .in_flight(d_state == D_WRITE), .enq(enq), .merge(merge), .pop(pop),
    .hit(hit), .hit_in_flight(hit_in_flight), .hit_data(hit_data),
    .head_tag(head_tag), .head_data(head_data), .full(full), .empty(empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      u_state <= U_IDLE;
      d_state <= D_IDLE;
    end else begin
      u_state <= u_nxt;
      d_state <= d_nxt;
    end
  end

  // Upstream: hits and writes complete locally, misses hand a fill to the downstream FSM.
  always_comb begin
    u_nxt     = u_state;
    enq       = 1'b0;
    merge     = 1'b0;
    load_hit  = 1'b0;
    load_fill = 1'b0;
    post_fill = 1'b0;
    unique case (u_state)
      U_IDLE: begin
        if (read_i) begin
          if (hit) begin
            load_hit = 1'b1;
            u_nxt    = U_RESP;
          end else begin
            post_fill = 1'b1;
            u_nxt     = U_WAIT;
          end
        end else if (write_i) begin
          if (hit && !hit_in_flight) begin
            merge = 1'b1;
            u_nxt = U_RESP;
          end else if (!full) begin
            enq   = 1'b1;
            u_nxt = U_RESP;
          end
        end
      end
      U_RESP: u_nxt = U_IDLE;
      U_WAIT: begin
        if (d_state == D_READ && dn_resp_i) begin
          load_fill = 1'b1;
          u_nxt     = U_RESP;
        end
      end
      default: u_nxt = U_IDLE;
    endcase
  end

  // Downstream: a waiting fill beats the next drain; a started drain always completes.
  always_comb begin
    d_nxt = d_state;
    pop   = 1'b0;
    unique case (d_state)
      D_IDLE: begin
        if (u_state == U_WAIT) d_nxt = D_READ;
        else if (!empty)       d_nxt = D_WRITE;
      end
      D_READ:  if (dn_resp_i) d_nxt = D_IDLE;
      D_WRITE: begin
        if (dn_resp_i) begin
          pop   = 1'b1;
          d_nxt = D_IDLE;
        end
      end
      default: d_nxt = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_o   <= 1'b0;
      line_o   <= '0;
      fill_tag <= '0;
    end else begin
      resp_o <= (u_nxt == U_RESP);
      if (load_hit)       line_o <= hit_data;
      else if (load_fill) line_o <= dn_line_i;
      if (post_fill) fill_tag <= req_tag;
    end
  end

  // Downstream request decoded from registered state and entry storage only.
  always_comb begin
    dn_read_o  = 1'b0;
    dn_write_o = 1'b0;
    dn_addr_o  = '0;
    dn_line_o  = '0;
    if (d_state == D_READ) begin
      dn_read_o = 1'b1;
      dn_addr_o = {fill_tag, {S_OFFSET{1'b0}}};
    end else if (d_state == D_WRITE) begin
      dn_write_o = 1'b1;
      dn_addr_o  = {head_tag, {S_OFFSET{1'b0}}};
      dn_line_o  = head_data;
    end
  end

  assign empty_o = empty;

  a_no_rd_wr: assert property (@(posedge clk) disable iff (!reset_n) !(read_i && write_i));
endmodule

// File: tb/tb_eviction_write_buffer.sv
// Directed bench for eviction_write_buffer with a scripted arbiter model.
module tb_eviction_write_buffer;
  logic         clk, reset_n;
  logic [255:0] line_i, line_o, dn_line_o, dn_line_i;
  logic [31:0]  address_i, dn_addr_o;
  logic         read_i, write_i, resp_o, dn_read_o, dn_write_o, dn_resp_i, empty_o;

  eviction_write_buffer dut (
    .clk(clk), .reset_n(reset_n), .line_i(line_i), .address_i(address_i),
    .read_i(read_i), .write_i(write_i), .line_o(line_o), .resp_o(resp_o),
    .dn_line_o(dn_line_o), .dn_addr_o(dn_addr_o), .dn_read_o(dn_read_o),
    .dn_write_o(dn_write_o), .dn_line_i(dn_line_i), .dn_resp_i(dn_resp_i),
    .empty_o(empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;

  typedef struct {
    bit           rd;
    logic [31:0]  addr;
    logic [255:0] data;
    int           exp_lat;
    bit           chk_line;
    logic [255:0] exp_line;
  } vec_t;

  txn_t log_q[$];
  bit   arb_hold;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [255:0] pat(input logic [31:0] w);
    return {8{w}};
  endfunction

  function automatic logic [255:0] rdata(input logic [31:0] a);
    return {8{a ^ 32'hDEAD_0000}};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Arbiter: answers the current request in the same cycle unless held.
  initial begin
    txn_t t;
    dn_resp_i = 1'b0;
    dn_line_i = '0;
    forever begin
      @(posedge clk); #1;
      dn_resp_i = 1'b0;
      if (reset_n && !arb_hold && (dn_read_o || dn_write_o)) begin
        t.wr   = dn_write_o;
        t.addr = dn_addr_o;
        t.data = dn_write_o ? dn_line_o : rdata(dn_addr_o);
        log_q.push_back(t);
        dn_line_i = rdata(dn_addr_o);
        dn_resp_i = 1'b1;
      end
    end
  end

  // Holds one upstream request until resp_o; indices count negedges from issue (0 = issue cycle).
  task automatic up_req(input bit rd, input logic [31:0] addr, input logic [255:0] data,
                        input int budget, output int lat, output logic [255:0] rline,
                        output logic emp, output int rd_at, output int wr_at);
    lat = -1; rd_at = -1; wr_at = -1; rline = '0; emp = 1'bx;
    read_i = rd; write_i = !rd; address_i = addr; line_i = data;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dn_resp_i && dn_read_o && rd_at < 0)  rd_at = i;
      if (dn_resp_i && dn_write_o && wr_at < 0) wr_at = i;
      if (resp_o) begin
        lat = i; rline = line_o; emp = empty_o;
        break;
      end
    end
    @(posedge clk); #1;
    read_i = 1'b0; write_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (empty_o && !dn_read_o && !dn_write_o) begin ok = 1'b1; break; end
    end
    chk(name, 256'(ok), 256'(1));
    @(posedge clk); #1;
  endtask

  task automatic chk_log(input string name, input txn_t exp[$]);
    chk({name, "_len"}, 256'(log_q.size()), 256'(exp.size()));
    for (int i = 0; i < exp.size() && i < log_q.size(); i++) begin
      chk($sformatf("%s_wr%0d", name, i), 256'(log_q[i].wr), 256'(exp[i].wr));
      chk($sformatf("%s_addr%0d", name, i), 256'(log_q[i].addr), 256'(exp[i].addr));
      chk($sformatf("%s_data%0d", name, i), log_q[i].data, exp[i].data);
    end
    log_q.delete();
  endtask

  initial begin
    vec_t vecs[5];
    txn_t exp_q[$];
    int lat, rd_at, wr_at;
    logic [255:0] rl;
    logic emp;

    vecs[0] = '{1'b1, 32'h100, '0,               1, 1'b1, pat(32'hAAAA_0001)};
    vecs[1] = '{1'b0, 32'h120, pat(32'hBBBB_0002), 1, 1'b0, '0};
    vecs[2] = '{1'b0, 32'h13F, pat(32'hCCCC_0003), 1, 1'b0, '0};
    vecs[3] = '{1'b1, 32'h120, '0,               1, 1'b1, pat(32'hCCCC_0003)};
    vecs[4] = '{1'b1, 32'h101, '0,               1, 1'b1, pat(32'hAAAA_0001)};

    reset_n = 1'b0; read_i = 1'b0; write_i = 1'b0; address_i = '0; line_i = '0;
    arb_hold = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp", 256'(resp_o), 256'(0));
    chk("rst_dn_read", 256'(dn_read_o), 256'(0));
    chk("rst_dn_write", 256'(dn_write_o), 256'(0));
    chk("rst_empty", 256'(empty_o), 256'(1));
    chk("rst_line_o", line_o, '0);
    chk("rst_dn_addr", 256'(dn_addr_o), 256'(0));
    chk("rst_dn_line", dn_line_o, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Write to empty buffer, then drain starts the cycle after resp_o.
    up_req(1'b0, 32'h100, pat(32'hAAAA_0001), 10, lat, rl, emp, rd_at, wr_at);
    chk("t1_lat", 256'(lat), 256'(1));
    chk("t1_empty", 256'(emp), 256'(0));
    @(negedge clk);
    chk("t1_dn_write", 256'(dn_write_o), 256'(1));
    chk("t1_dn_addr", 256'(dn_addr_o), 256'(32'h100));
    chk("t1_dn_line", dn_line_o, pat(32'hAAAA_0001));
    @(posedge clk); #1;

    // Hits on the draining line and merges while the arbiter stalls.
    for (int v = 0; v < 5; v++) begin
      up_req(vecs[v].rd, vecs[v].addr, vecs[v].data, 10, lat, rl, emp, rd_at, wr_at);
      chk($sformatf("vec%0d_lat", v), 256'(lat), 256'(vecs[v].exp_lat));
      if (vecs[v].chk_line) chk($sformatf("vec%0d_line", v), rl, vecs[v].exp_line);
    end
    arb_hold = 1'b0;
    wait_idle("vec_drain");
    exp_q = '{'{1'b1, 32'h100, pat(32'hAAAA_0001)}, '{1'b1, 32'h120, pat(32'hCCCC_0003)}};
    chk_log("vec_log", exp_q);

    // Full stall: third write accepted only after the first drain pops.
    arb_hold = 1'b1;
    up_req(1'b0, 32'h100, pat(32'h1111_0001), 10, lat, rl, emp, rd_at, wr_at);
    up_req(1'b0, 32'h200, pat(32'h2222_0002), 10, lat, rl, emp, rd_at, wr_at);
    fork begin repeat (5) @(negedge clk); arb_hold = 1'b0; end join_none
    up_req(1'b0, 32'h300, pat(32'h3333_0003), 30, lat, rl, emp, rd_at, wr_at);
    chk("t3_pop_at", 256'(wr_at), 256'(5));
    chk("t3_lat", 256'(lat), 256'(7));
    wait_idle("t3_drain");
    exp_q = '{'{1'b1, 32'h100, pat(32'h1111_0001)}, '{1'b1, 32'h200, pat(32'h2222_0002)},
              '{1'b1, 32'h300, pat(32'h3333_0003)}};
    chk_log("t3_log", exp_q);

    // Fill posted during a drain goes ahead of the remaining queued line.
    arb_hold = 1'b1;
    up_req(1'b0, 32'h100, pat(32'hAAAA_0004), 10, lat, rl, emp, rd_at, wr_at);
    up_req(1'b0, 32'h200, pat(32'hBBBB_0005), 10, lat, rl, emp, rd_at, wr_at);
    fork begin repeat (3) @(negedge clk); arb_hold = 1'b0; end join_none
    up_req(1'b1, 32'h400, '0, 30, lat, rl, emp, rd_at, wr_at);
    chk("t4_rd_at", 256'(rd_at), 256'(5));
    chk("t4_lat", 256'(lat), 256'(6));
    chk("t4_line", rl, rdata(32'h400));
    wait_idle("t4_drain");
    exp_q = '{'{1'b1, 32'h100, pat(32'hAAAA_0004)}, '{1'b0, 32'h400, rdata(32'h400)},
              '{1'b1, 32'h200, pat(32'hBBBB_0005)}};
    chk_log("t4_log", exp_q);

    // Second write to a queued, not-yet-draining line merges into it.
    arb_hold = 1'b1;
    up_req(1'b0, 32'h100, pat(32'hAAAA_0006), 10, lat, rl, emp, rd_at, wr_at);
    up_req(1'b0, 32'h200, pat(32'hBBBB_0007), 10, lat, rl, emp, rd_at, wr_at);
    up_req(1'b0, 32'h200, pat(32'hCCCC_0008), 10, lat, rl, emp, rd_at, wr_at);
    chk("t5_merge_lat", 256'(lat), 256'(1));
    arb_hold = 1'b0;
    wait_idle("t5_drain");
    exp_q = '{'{1'b1, 32'h100, pat(32'hAAAA_0006)}, '{1'b1, 32'h200, pat(32'hCCCC_0008)}};
    chk_log("t5_log", exp_q);

    // Reset in the middle of a drain with resp_o high.
    arb_hold = 1'b1;
    up_req(1'b0, 32'h100, pat(32'hAAAA_0009), 10, lat, rl, emp, rd_at, wr_at);
    write_i = 1'b1; address_i = 32'h200; line_i = pat(32'hBBBB_000A);
    @(posedge clk); #1;
    chk("t6_pre_resp", 256'(resp_o), 256'(1));
    chk("t6_pre_dn_write", 256'(dn_write_o), 256'(1));
    reset_n = 1'b0;
    #1;
    chk("t6_resp", 256'(resp_o), 256'(0));
    chk("t6_dn_write", 256'(dn_write_o), 256'(0));
    chk("t6_empty", 256'(empty_o), 256'(1));
    chk("t6_dn_addr", 256'(dn_addr_o), 256'(0));
    write_i = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    arb_hold = 1'b0;
    up_req(1'b0, 32'h500, pat(32'h5555_000B), 10, lat, rl, emp, rd_at, wr_at);
    chk("t6_post_lat", 256'(lat), 256'(1));
    wait_idle("t6_drain");
    exp_q = '{'{1'b1, 32'h500, pat(32'h5555_000B)}};
    chk_log("t6_log", exp_q);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
